// File: rtl/sched_pkg.sv
// Shared types and constants for the execution-side ack responder.
// Imported by the per-lane FSM and the top-level scoreboard.
package sched_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      OP_ALU  = 2'd0,
      OP_MUL  = 2'd1,
      OP_LOAD = 2'd2,
      OP_NOP  = 2'd3
   } op_kind_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } lane_state_t;

   // MUL and LOAD occupy the lane for several cycles and claim a scoreboard bit.
   function automatic logic is_multi(input op_kind_t kind);
      return (kind == OP_MUL) || (kind == OP_LOAD);
   endfunction

endpackage

// File: rtl/ack_lane.sv
// One execution lane: IDLE/EXEC FSM, latency down-counter and registered
// writeback pulse. Exposes a combinational retire strobe for the scoreboard.
module ack_lane
   import sched_pkg::*;
#(
   parameter int MUL_LAT  = 3,
   parameter int LOAD_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             accept,
   input  op_kind_t         kind,
   input  logic [REG_W-1:0] rd,
   output logic             ack,
   output logic             wb_valid,
   output logic [REG_W-1:0] wb_rd,
   output logic             retire,
   output logic [REG_W-1:0] retire_rd
);

   localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);
   localparam logic [3:0] LOAD_CNT = 4'(LOAD_LAT - 1);

   lane_state_t      state;
   logic [3:0]       cnt;
   logic [REG_W-1:0] rd_hold;

   // NOTE: ack depends only on the state register and rst, never on the issue
   // inputs, so the scheduler can use it without a combinational loop.
   assign ack       = (state == ST_IDLE) && !rst;
   assign retire    = (state == ST_EXEC) && (cnt == 4'd1);
   assign retire_rd = rd_hold;

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         rd_hold  <= '0;
         wb_valid <= 1'b0;
         wb_rd    <= '0;
      end else begin
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         if (flush) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (accept) begin
                     unique case (kind)
                        OP_ALU: begin
                           if (rd != '0) begin
                              wb_valid <= 1'b1;
                              wb_rd    <= rd;
                           end
                        end
                        OP_MUL: begin
                           state   <= ST_EXEC;
                           cnt     <= MUL_CNT;
                           rd_hold <= rd;
                        end
                        OP_LOAD: begin
                           state   <= ST_EXEC;
                           cnt     <= LOAD_CNT;
                           rd_hold <= rd;
                        end
                        OP_NOP: ;
                     endcase
                  end
               end
               ST_EXEC: begin
                  if (cnt == 4'd1) begin
                     state <= ST_IDLE;
                     cnt   <= 4'd0;
                     if (rd_hold != '0) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_hold;
                     end
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/issue_ack_unit.sv
// Dual-lane execution responder: per-lane acceptance, cross-lane conflict
// check, pending-destination scoreboard, flush fan-out and sticky proto_err.
module issue_ack_unit
   import sched_pkg::*;
#(
   parameter int MUL_LAT  = 3,
   parameter int LOAD_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             issue1_valid,
   input  logic [1:0]       issue1_kind,
   input  logic [REG_W-1:0] issue1_rd,
   input  logic             issue2_valid,
   input  logic [1:0]       issue2_kind,
   input  logic [REG_W-1:0] issue2_rd,
   output logic             ack1,
   output logic             ack2,
   output logic             wb1_valid,
   output logic [REG_W-1:0] wb1_rd,
   output logic             wb2_valid,
   output logic [REG_W-1:0] wb2_rd,
   output logic [31:0]      busy_mask,
   output logic             proto_err
);

   op_kind_t         kind1, kind2;
   logic             late1, late2, hazard1, hazard2, conflict;
   logic             accept1, accept2, violation;
   logic             retire1, retire2;
   logic [REG_W-1:0] retire1_rd, retire2_rd;
   logic [31:0]      set_mask, clr_mask;

   assign kind1 = op_kind_t'(issue1_kind);
   assign kind2 = op_kind_t'(issue2_kind);

   assign late1    = issue1_valid && !ack1;
   assign late2    = issue2_valid && !ack2;
   assign hazard1  = issue1_valid && ack1 && (kind1 != OP_NOP) &&
                     (issue1_rd != '0) && busy_mask[issue1_rd];
   assign hazard2  = issue2_valid && ack2 && (kind2 != OP_NOP) &&
                     (issue2_rd != '0) && busy_mask[issue2_rd];
   // Same-destination collision drops lane 2; lane 1 keeps program order.
   assign conflict = issue1_valid && issue2_valid && (kind1 != OP_NOP) &&
                     (kind2 != OP_NOP) && (issue1_rd == issue2_rd) && (issue1_rd != '0);

   assign accept1   = issue1_valid && ack1 && !flush && !hazard1;
   assign accept2   = issue2_valid && ack2 && !flush && !hazard2 && !conflict;
   assign violation = !flush && (late1 || late2 || hazard1 || hazard2 || conflict);

   ack_lane #(.MUL_LAT(MUL_LAT), .LOAD_LAT(LOAD_LAT)) u_lane1 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .accept    (accept1),
      .kind      (kind1),
      .rd        (issue1_rd),
      .ack       (ack1),
      .wb_valid  (wb1_valid),
      .wb_rd     (wb1_rd),
      .retire    (retire1),
      .retire_rd (retire1_rd)
   );

   ack_lane #(.MUL_LAT(MUL_LAT), .LOAD_LAT(LOAD_LAT)) u_lane2 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .accept    (accept2),
      .kind      (kind2),
      .rd        (issue2_rd),
      .ack       (ack2),
      .wb_valid  (wb2_valid),
      .wb_rd     (wb2_rd),
      .retire    (retire2),
      .retire_rd (retire2_rd)
   );

   // NOTE: both masks get a default before any conditional write, so no
   // latch is inferred.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (retire1) clr_mask[retire1_rd] = 1'b1;
      if (retire2) clr_mask[retire2_rd] = 1'b1;
      if (accept1 && is_multi(kind1) && (issue1_rd != '0)) set_mask[issue1_rd] = 1'b1;
      if (accept2 && is_multi(kind2) && (issue2_rd != '0)) set_mask[issue2_rd] = 1'b1;
   end

   // Set is applied after clear so a same-edge collision leaves the bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_mask <= '0;
         proto_err <= 1'b0;
      end else begin
         busy_mask <= flush ? '0 : ((busy_mask & ~clr_mask) | set_mask);
         if (violation) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_issue_ack_unit.sv
// Self-checking bench for issue_ack_unit: directed scenarios followed by random
// traffic, compared every cycle against a cycle-number based reference model.
module tb_issue_ack_unit;

   localparam int MUL_LAT  = 3;
   localparam int LOAD_LAT = 2;
   localparam int K_ALU = 0, K_MUL = 1, K_LOAD = 2, K_NOP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        issue1_valid = 1'b0, issue2_valid = 1'b0;
   logic [1:0]  issue1_kind = 2'd3, issue2_kind = 2'd3;
   logic [4:0]  issue1_rd = '0, issue2_rd = '0;
   logic        ack1, ack2, wb1_valid, wb2_valid, proto_err;
   logic [4:0]  wb1_rd, wb2_rd;
   logic [31:0] busy_mask;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: everything is a cycle number relative to reset release.
   int   n;
   int   lane_free [2];
   int   wb_due    [2];
   int   wb_rd_exp [2];
   int   busy_until[32];
   bit   err_exp;

   issue_ack_unit #(.MUL_LAT(MUL_LAT), .LOAD_LAT(LOAD_LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .issue1_valid (issue1_valid),
      .issue1_kind  (issue1_kind),
      .issue1_rd    (issue1_rd),
      .issue2_valid (issue2_valid),
      .issue2_kind  (issue2_kind),
      .issue2_rd    (issue2_rd),
      .ack1         (ack1),
      .ack2         (ack2),
      .wb1_valid    (wb1_valid),
      .wb1_rd       (wb1_rd),
      .wb2_valid    (wb2_valid),
      .wb2_rd       (wb2_rd),
      .busy_mask    (busy_mask),
      .proto_err    (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, n, got, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      err_exp = 1'b0;
      for (int i = 0; i < 2; i++) begin
         lane_free[i] = 0;
         wb_due[i]    = -1;
         wb_rd_exp[i] = 0;
      end
      for (int r = 0; r < 32; r++) busy_until[r] = 0;
   endtask

   task automatic check_cycle();
      logic [31:0] bexp;
      bexp = '0;
      for (int r = 0; r < 32; r++) bexp[r] = (n < busy_until[r]);
      check("ack1", 32'(ack1), 32'(n >= lane_free[0]));
      check("ack2", 32'(ack2), 32'(n >= lane_free[1]));
      check("wb1_valid", 32'(wb1_valid), 32'(wb_due[0] == n));
      check("wb2_valid", 32'(wb2_valid), 32'(wb_due[1] == n));
      if (wb_due[0] == n) check("wb1_rd", 32'(wb1_rd), 32'(wb_rd_exp[0]));
      if (wb_due[1] == n) check("wb2_rd", 32'(wb2_rd), 32'(wb_rd_exp[1]));
      check("busy_mask", busy_mask, bexp);
      check("proto_err", 32'(proto_err), 32'(err_exp));
   endtask

   // Apply the rules for one cycle of issue traffic observed at cycle n.
   task automatic model_issue(input bit v[2], input int k[2], input int r[2], input bit fl);
      bit take[2];
      bit conflict;
      if (fl) begin
         for (int i = 0; i < 2; i++) begin
            lane_free[i] = n + 1;
            wb_due[i]    = -1;
         end
         for (int b = 0; b < 32; b++) busy_until[b] = 0;
         return;
      end
      conflict = v[0] && v[1] && k[0] != K_NOP && k[1] != K_NOP && r[0] == r[1] && r[0] != 0;
      for (int i = 0; i < 2; i++) begin
         take[i] = 1'b0;
         if (v[i]) begin
            if (n < lane_free[i]) err_exp = 1'b1;
            else if (k[i] != K_NOP && r[i] != 0 && n < busy_until[r[i]]) err_exp = 1'b1;
            else if (i == 1 && conflict) err_exp = 1'b1;
            else take[i] = 1'b1;
         end
      end
      if (conflict) err_exp = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (take[i]) begin
            if (k[i] == K_ALU && r[i] != 0) begin
               wb_due[i]    = n + 1;
               wb_rd_exp[i] = r[i];
            end else if (k[i] == K_MUL || k[i] == K_LOAD) begin
               int lat;
               lat = (k[i] == K_MUL) ? MUL_LAT : LOAD_LAT;
               lane_free[i] = n + lat;
               if (r[i] != 0) begin
                  wb_due[i]        = n + lat;
                  wb_rd_exp[i]     = r[i];
                  busy_until[r[i]] = n + lat;
               end
            end
         end
      end
   endtask

   task automatic step(input bit v1, input int k1, input int r1,
                       input bit v2, input int k2, input int r2, input bit fl);
      bit v[2];
      int k[2];
      int r[2];
      v = '{v1, v2};
      k = '{k1, k2};
      r = '{r1, r2};
      issue1_valid = v1;  issue1_kind = 2'(k1);  issue1_rd = 5'(r1);
      issue2_valid = v2;  issue2_kind = 2'(k2);  issue2_rd = 5'(r2);
      flush        = fl;
      model_issue(v, k, r, fl);
      @(posedge clk);
      #1;
      n++;
      issue1_valid = 1'b0;  issue2_valid = 1'b0;  flush = 1'b0;
      check_cycle();
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, K_NOP, 0, 0, K_NOP, 0, 0);
   endtask

   task automatic check_reset_values(input string where);
      check({where, "_ack1"}, 32'(ack1), 32'd0);
      check({where, "_ack2"}, 32'(ack2), 32'd0);
      check({where, "_wb1"}, 32'(wb1_valid), 32'd0);
      check({where, "_wb2"}, 32'(wb2_valid), 32'd0);
      check({where, "_wb1_rd"}, 32'(wb1_rd), 32'd0);
      check({where, "_wb2_rd"}, 32'(wb2_rd), 32'd0);
      check({where, "_busy"}, busy_mask, 32'd0);
      check({where, "_err"}, 32'(proto_err), 32'd0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      check_cycle();
   endtask

   initial begin
      #1;
      check_reset_values("rst_hold");
      release_reset();

      // Lane 1 ALU rd=5: one-cycle writeback, lane stays available.
      step(1, K_ALU, 5, 0, K_NOP, 0, 0);
      idle(1);

      // Lane 2 MUL rd=7, then a fresh issue on the writeback cycle.
      step(0, K_NOP, 0, 1, K_MUL, 7, 0);
      idle(2);
      step(0, K_NOP, 0, 1, K_ALU, 8, 0);
      idle(1);

      // Dual ALU throughput, including rd=0 suppression.
      step(1, K_ALU, 1, 1, K_ALU, 2, 0);
      step(1, K_ALU, 3, 1, K_ALU, 0, 0);
      idle(1);

      // MUL with rd=0: lane occupied but no writeback or busy bit.
      step(1, K_MUL, 0, 0, K_NOP, 0, 0);
      idle(3);

      // Flush one cycle after a MUL issue, and a flush on the cycle before a LOAD is due.
      step(1, K_MUL, 3, 0, K_NOP, 0, 0);
      step(0, K_NOP, 0, 0, K_NOP, 0, 1);
      idle(2);
      step(0, K_NOP, 0, 1, K_LOAD, 6, 0);
      step(1, K_ALU, 12, 1, K_ALU, 13, 1);
      idle(2);

      // Reset during an EXEC cycle of a LOAD.
      step(1, K_LOAD, 9, 0, K_NOP, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("rst_mid");
      release_reset();
      idle(3);

      // Same-rd dual LOAD: lane 1 proceeds, lane 2 dropped, sticky error.
      step(1, K_LOAD, 9, 1, K_LOAD, 9, 0);
      idle(3);
      check("conflict_err_sticky", 32'(proto_err), 32'd1);

      // Busy hazard and issue into a non-idle lane.
      release_reset_after_assert();
      step(1, K_MUL, 4, 0, K_NOP, 0, 0);
      step(0, K_NOP, 0, 1, K_ALU, 4, 0);
      idle(3);
      step(1, K_MUL, 10, 0, K_NOP, 0, 0);
      step(1, K_ALU, 11, 0, K_NOP, 0, 0);
      idle(3);
      step(0, K_NOP, 0, 0, K_NOP, 0, 1);
      check("err_survives_flush", 32'(proto_err), 32'd1);

      // Random traffic with a small register window to provoke hazards.
      for (int seg = 0; seg < 3; seg++) begin
         release_reset_after_assert();
         for (int c = 0; c < 150; c++) begin
            step($urandom_range(9, 0) < 6, int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
                 $urandom_range(9, 0) < 6, int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
                 $urandom_range(39, 0) == 0);
         end
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

   task automatic release_reset_after_assert();
      #2;
      rst = 1'b1;
      release_reset();
   endtask

endmodule
